// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN convolution stage.
//   wb_state_t   : weight-bank load state (EMPTY / LOADING / READY)
//   WB_DATA_W    : default weight width
//   WB_BIAS_W    : default bias / load-word width
//   KK(k)        : elements in a k x k kernel
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_BIAS_W = 32;

    typedef enum logic [1:0] {
        WB_EMPTY   = 2'd0,
        WB_LOADING = 2'd1,
        WB_READY   = 2'd2
    } wb_state_t;

    function automatic int KK(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/wb_load_ctrl.sv
// ---------------------------------------------------------------------------
// wb_load_ctrl
// Load sequencer of the weight bank: state machine plus filter/element
// counters walking the load stream (K*K weights then one bias per filter).
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset
//   i_load_start       : begin (or restart) a full reload
//   i_load_valid       : load beat presented
//   o_state            : current state
//   o_load_ready       : beats accepted (LOADING only)
//   o_full             : every filter holds valid data (READY)
//   o_ld_we            : a beat is being stored this cycle
//   o_ld_filt/o_ld_elem: where that beat goes; elem == K*K is the bias
// ---------------------------------------------------------------------------
module wb_load_ctrl
    import cnn_pkg::*;
#(
    parameter int K      = 3,
    parameter int N_FILT = 4,
    parameter int FW     = 2,
    parameter int EW     = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_load_start,
    input  logic            i_load_valid,
    output wb_state_t       o_state,
    output logic            o_load_ready,
    output logic            o_full,
    output logic            o_ld_we,
    output logic [FW-1:0]   o_ld_filt,
    output logic [EW-1:0]   o_ld_elem
);

    localparam logic [EW-1:0] LAST_E = EW'(KK(K));
    localparam logic [FW-1:0] LAST_F = FW'(N_FILT - 1);

    wb_state_t       r_state;
    wb_state_t       w_state_nx;
    logic [FW-1:0]   r_filt;
    logic [FW-1:0]   w_filt_nx;
    logic [EW-1:0]   r_elem;
    logic [EW-1:0]   w_elem_nx;
    logic            w_beat;

    // A restart in the same cycle as a beat wins; that beat is dropped.
    assign w_beat = (r_state == WB_LOADING) && i_load_valid && !i_load_start;

    // State and counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= WB_EMPTY;
            r_filt  <= '0;
            r_elem  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_filt  <= w_filt_nx;
            r_elem  <= w_elem_nx;
        end
    end

    // Next-state and counter advance.
    always_comb begin
        w_state_nx = r_state;
        w_filt_nx  = r_filt;
        w_elem_nx  = r_elem;
        if (i_load_start) begin
            w_state_nx = WB_LOADING;
            w_filt_nx  = '0;
            w_elem_nx  = '0;
        end else begin
            case (r_state)
                WB_LOADING: begin
                    if (w_beat) begin
                        if (r_elem == LAST_E) begin
                            w_elem_nx = '0;
                            if (r_filt == LAST_F) begin
                                w_filt_nx  = '0;
                                w_state_nx = WB_READY;
                            end else begin
                                w_filt_nx = r_filt + 1'b1;
                            end
                        end else begin
                            w_elem_nx = r_elem + 1'b1;
                        end
                    end else begin
                        w_state_nx = WB_LOADING;
                    end
                end
                WB_EMPTY: w_state_nx = WB_EMPTY;
                WB_READY: w_state_nx = WB_READY;
                default:  w_state_nx = WB_EMPTY;
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_load_ready = (r_state == WB_LOADING);
    assign o_full       = (r_state == WB_READY);
    assign o_ld_we      = w_beat;
    assign o_ld_filt    = r_filt;
    assign o_ld_elem    = r_elem;

endmodule

// File: rtl/conv_weight_bank.sv
// ---------------------------------------------------------------------------
// conv_weight_bank
// Run-time loadable store of N_FILT signed KxK kernels plus one bias each.
// Ports:
//   clk, rstn                     : clock, asynchronous active-low reset
//   load_start/valid/data/ready   : full reload stream
//   wr_en/filt/idx/data           : single-element patch (idx K*K = bias)
//   rd_req/rd_filt                : kernel read request
//   rd_valid/kernel/bias/miss     : registered response, one cycle later
//   full                          : all filters hold valid data
// ---------------------------------------------------------------------------
module conv_weight_bank
    import cnn_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int BIAS_W = WB_BIAS_W,
    parameter  int K      = 3,
    parameter  int N_FILT = 4,
    localparam int FW     = (N_FILT > 1) ? $clog2(N_FILT) : 1,
    localparam int EW     = $clog2(K * K + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [BIAS_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic                  wr_en,
    input  logic [FW-1:0]         wr_filt,
    input  logic [EW-1:0]         wr_idx,
    input  logic [BIAS_W-1:0]     wr_data,
    input  logic                  rd_req,
    input  logic [FW-1:0]         rd_filt,
    output logic                  rd_valid,
    output logic [K*K*DATA_W-1:0] rd_kernel,
    output logic [BIAS_W-1:0]     rd_bias,
    output logic                  rd_miss,
    output logic                  full
);

    localparam int            KK_N = KK(K);
    localparam logic [EW-1:0] KK_E = EW'(KK_N);
    localparam logic [FW:0]   NF_C = (FW + 1)'(N_FILT);

    logic [DATA_W-1:0]     r_wt [N_FILT][KK_N];
    logic [BIAS_W-1:0]     r_bias [N_FILT];

    wb_state_t             w_state;
    logic                  w_ld_we;
    logic [FW-1:0]         w_ld_filt;
    logic [EW-1:0]         w_ld_elem;
    logic                  w_rd_hit;
    logic                  w_patch;
    logic [FW-1:0]         w_rd_sel;
    logic [K*K*DATA_W-1:0] w_kernel;

    logic                  r_rd_valid;
    logic                  r_rd_miss;
    logic [K*K*DATA_W-1:0] r_rd_kernel;
    logic [BIAS_W-1:0]     r_rd_bias;

    wb_load_ctrl #(
        .K      (K),
        .N_FILT (N_FILT),
        .FW     (FW),
        .EW     (EW)
    ) u_ctrl (
        .clk          (clk),
        .rstn         (rstn),
        .i_load_start (load_start),
        .i_load_valid (load_valid),
        .o_state      (w_state),
        .o_load_ready (load_ready),
        .o_full       (full),
        .o_ld_we      (w_ld_we),
        .o_ld_filt    (w_ld_filt),
        .o_ld_elem    (w_ld_elem)
    );

    // Filter index is compared one bit wider so non-power-of-two banks reject the gap.
    assign w_rd_hit = (w_state == WB_READY) && ({1'b0, rd_filt} < NF_C);
    assign w_patch  = wr_en && (w_state == WB_READY) &&
                      ({1'b0, wr_filt} < NF_C) && (wr_idx <= KK_E);

    // Kernel gather; out-of-range requests steer to filter 0 so no index overruns.
    always_comb begin
        w_rd_sel = '0;
        w_kernel = '0;
        if (w_rd_hit) begin
            w_rd_sel = rd_filt;
        end else begin
            w_rd_sel = '0;
        end
        for (int e = 0; e < KK_N; e++) begin
            w_kernel[e*DATA_W +: DATA_W] = r_wt[w_rd_sel][e];
        end
    end

    // Storage: load stream in LOADING, patches in READY (never both at once).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int f = 0; f < N_FILT; f++) begin
                r_bias[f] <= '0;
                for (int e = 0; e < KK_N; e++) begin
                    r_wt[f][e] <= '0;
                end
            end
        end else if (w_ld_we) begin
            if (w_ld_elem == KK_E) begin
                r_bias[w_ld_filt] <= load_data;
            end else begin
                r_wt[w_ld_filt][w_ld_elem] <= load_data[DATA_W-1:0];
            end
        end else if (w_patch) begin
            if (wr_idx == KK_E) begin
                r_bias[wr_filt] <= wr_data;
            end else begin
                r_wt[wr_filt][wr_idx] <= wr_data[DATA_W-1:0];
            end
        end
    end

    // Read response: hit captures pre-write contents, refusal zeroes data, idle holds it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_valid  <= 1'b0;
            r_rd_miss   <= 1'b0;
            r_rd_kernel <= '0;
            r_rd_bias   <= '0;
        end else if (rd_req) begin
            if (w_rd_hit) begin
                r_rd_valid  <= 1'b1;
                r_rd_miss   <= 1'b0;
                r_rd_kernel <= w_kernel;
                r_rd_bias   <= r_bias[w_rd_sel];
            end else begin
                r_rd_valid  <= 1'b0;
                r_rd_miss   <= 1'b1;
                r_rd_kernel <= '0;
                r_rd_bias   <= '0;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_miss  <= 1'b0;
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_miss   = r_rd_miss;
    assign rd_kernel = r_rd_kernel;
    assign rd_bias   = r_rd_bias;

endmodule
